// File: rtl/rename_map_stage.sv
// Register-rename stage: arch->phys map, free-list handshake and a history buffer
// of rename records used for in-order commit and youngest-first flush walk-back.
module rename_map_stage #(
    parameter int ARCH_REGS  = 32,
    parameter int PHYS_REGS  = 64,
    parameter int PREG_W     = 6,
    parameter int HIST_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        arch_rs,
    input  logic [4:0]        arch_rt,
    input  logic [4:0]        arch_rd,
    input  logic              rd_wr,
    input  logic              free_valid,
    input  logic [PREG_W-1:0] free_preg,
    output logic              free_pop,
    output logic              free_push,
    output logic [PREG_W-1:0] free_push_preg,
    output logic              out_valid,
    output logic [PREG_W-1:0] phys_rs,
    output logic [PREG_W-1:0] phys_rt,
    output logic [PREG_W-1:0] phys_rd,
    output logic [PREG_W-1:0] old_phys_rd,
    input  logic              commit_en,
    input  logic              flush,
    output logic              flush_busy
);
    localparam int HP_W  = $clog2(HIST_DEPTH);
    localparam int CNT_W = HP_W + 1;

    if ((1 << PREG_W) < PHYS_REGS) begin : g_preg_w_check
        $error("PREG_W too narrow for PHYS_REGS");
    end

    typedef enum logic {RUN, WALK} state_t;

    state_t            state_q, state_d;
    logic [PREG_W-1:0] map_q [ARCH_REGS];
    logic [4:0]        hist_arch_q [HIST_DEPTH];
    logic [PREG_W-1:0] hist_new_q  [HIST_DEPTH];
    logic [PREG_W-1:0] hist_old_q  [HIST_DEPTH];
    logic [HP_W-1:0]   head_q, tail_q, tail_last;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              out_valid_q, free_push_q, flush_busy_q;
    logic [PREG_W-1:0] phys_rs_q, phys_rt_q, phys_rd_q, old_phys_rd_q, free_push_preg_q;

    logic alloc, hist_empty, hist_full, fire, push_rec, commit, walk_step;

    assign alloc      = rd_wr && (arch_rd != 5'd0);
    assign hist_empty = (cnt_q == '0);
    assign hist_full  = (cnt_q == CNT_W'(HIST_DEPTH));
    assign in_ready   = (state_q == RUN) && !flush && !hist_full && (!alloc || free_valid);
    assign fire       = in_valid && in_ready;
    assign push_rec   = fire && alloc;
    assign free_pop   = push_rec;
    assign commit     = (state_q == RUN) && commit_en && !hist_empty;
    assign walk_step  = (state_q == WALK);
    assign tail_last  = tail_q - 1'b1;

    // In RUN a flush cannot fire, so cnt_d there is occupancy after any commit.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (walk_step) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == '0) state_d = RUN;
        end else begin
            cnt_d = cnt_q + CNT_W'(push_rec) - CNT_W'(commit);
            if (flush && (cnt_d != '0)) state_d = WALK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            head_q           <= '0;
            tail_q           <= '0;
            cnt_q            <= '0;
            out_valid_q      <= 1'b0;
            phys_rs_q        <= '0;
            phys_rt_q        <= '0;
            phys_rd_q        <= '0;
            old_phys_rd_q    <= '0;
            free_push_q      <= 1'b0;
            free_push_preg_q <= '0;
            flush_busy_q     <= 1'b0;
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PREG_W'(i);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_busy_q <= (state_d == WALK);

            out_valid_q   <= fire;
            phys_rs_q     <= fire ? map_q[arch_rs] : '0;
            phys_rt_q     <= fire ? map_q[arch_rt] : '0;
            phys_rd_q     <= push_rec ? free_preg : '0;
            old_phys_rd_q <= push_rec ? map_q[arch_rd] : '0;

            free_push_q      <= commit || walk_step;
            free_push_preg_q <= commit    ? hist_old_q[head_q]    :
                                walk_step ? hist_new_q[tail_last] : '0;

            if (push_rec) begin
                map_q[arch_rd] <= free_preg;
                tail_q         <= tail_q + 1'b1;
            end
            if (commit) head_q <= head_q + 1'b1;
            // Undo youngest record: restore its previous mapping and retreat the tail.
            if (walk_step) begin
                map_q[hist_arch_q[tail_last]] <= hist_old_q[tail_last];
                tail_q                        <= tail_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_rec) begin
            hist_arch_q[tail_q] <= arch_rd;
            hist_new_q[tail_q]  <= free_preg;
            hist_old_q[tail_q]  <= map_q[arch_rd];
        end
    end

    assign out_valid      = out_valid_q;
    assign phys_rs        = phys_rs_q;
    assign phys_rt        = phys_rt_q;
    assign phys_rd        = phys_rd_q;
    assign old_phys_rd    = old_phys_rd_q;
    assign free_push      = free_push_q;
    assign free_push_preg = free_push_preg_q;
    assign flush_busy     = flush_busy_q;

endmodule

// File: tb/tb_rename_map_stage.sv
// Directed bench for rename_map_stage: rename, dependency, flush walk, full history, reset.
module tb_rename_map_stage;
    logic       clk, rst_n;
    logic       in_valid, in_ready, rd_wr, free_valid, free_pop, free_push;
    logic [4:0] arch_rs, arch_rt, arch_rd;
    logic [5:0] free_preg, free_push_preg, phys_rs, phys_rt, phys_rd, old_phys_rd;
    logic       out_valid, commit_en, flush, flush_busy;

    int errors = 0;
    int checks = 0;

    rename_map_stage #(.ARCH_REGS(32), .PHYS_REGS(64), .PREG_W(6), .HIST_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .arch_rs(arch_rs), .arch_rt(arch_rt), .arch_rd(arch_rd), .rd_wr(rd_wr),
        .free_valid(free_valid), .free_preg(free_preg), .free_pop(free_pop),
        .free_push(free_push), .free_push_preg(free_push_preg), .out_valid(out_valid),
        .phys_rs(phys_rs), .phys_rt(phys_rt), .phys_rd(phys_rd), .old_phys_rd(old_phys_rd),
        .commit_en(commit_en), .flush(flush), .flush_busy(flush_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        assert (!(rst_n && flush_busy && commit_en)) else $error("commit_en raised during flush walk");

    logic [24:0] got_out;
    assign got_out = {out_valid, phys_rs, phys_rt, phys_rd, old_phys_rd};

    task automatic clr();
        in_valid = 0; arch_rs = 0; arch_rt = 0; arch_rd = 0; rd_wr = 0;
        free_valid = 0; free_preg = 0; commit_en = 0; flush = 0;
    endtask

    task automatic ren(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic wr, input logic [5:0] fp);
        in_valid = 1; arch_rs = rs; arch_rt = rt; arch_rd = rd; rd_wr = wr;
        free_valid = 1; free_preg = fp;
    endtask

    task automatic do_reset();
        @(negedge clk); clr(); rst_n = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_reset();
        clr(); rst_n = 0;
        @(negedge clk);
        checks++;
        if ({out_valid, free_push, flush_busy, free_pop} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {out_valid, free_push, flush_busy, free_pop});
        checks++;
        if ({phys_rs, phys_rt, phys_rd, old_phys_rd, free_push_preg} !== 30'd0)
            $display("FAIL reset_data: got %h expected 0", {phys_rs, phys_rt, phys_rd, old_phys_rd, free_push_preg});
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        if ({out_valid, free_push, flush_busy, free_pop} !== 4'b0000) errors++;
        if ({phys_rs, phys_rt, phys_rd, old_phys_rd, free_push_preg} !== 30'd0) errors++;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_rename_basic();
        do_reset();
        ren(1, 2, 5, 1, 32); #1;
        checks++;
        if ({in_ready, free_pop} !== 2'b11) begin
            errors++; $display("FAIL basic_pop: got %b expected 11", {in_ready, free_pop});
        end
        @(negedge clk); clr();
        checks++;
        if (got_out !== {1'b1, 6'd1, 6'd2, 6'd32, 6'd5}) begin
            errors++; $display("FAIL basic_out: got %h expected %h", got_out, {1'b1, 6'd1, 6'd2, 6'd32, 6'd5});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ren(1, 2, 5, 1, 32);
        @(negedge clk);
        checks++;
        if (got_out !== {1'b1, 6'd1, 6'd2, 6'd32, 6'd5}) begin
            errors++; $display("FAIL b2b_a: got %h expected %h", got_out, {1'b1, 6'd1, 6'd2, 6'd32, 6'd5});
        end
        ren(5, 0, 5, 1, 33);
        @(negedge clk); clr();
        checks++;
        if (got_out !== {1'b1, 6'd32, 6'd0, 6'd33, 6'd32}) begin
            errors++; $display("FAIL b2b_b: got %h expected %h", got_out, {1'b1, 6'd32, 6'd0, 6'd33, 6'd32});
        end
    endtask

    task automatic test_no_alloc();
        do_reset();
        ren(7, 8, 0, 1, 50); #1;
        checks++;
        if ({in_ready, free_pop} !== 2'b10) begin
            errors++; $display("FAIL rd0_pop: got %b expected 10", {in_ready, free_pop});
        end
        @(negedge clk);
        checks++;
        if (got_out !== {1'b1, 6'd7, 6'd8, 6'd0, 6'd0}) begin
            errors++; $display("FAIL rd0_out: got %h expected %h", got_out, {1'b1, 6'd7, 6'd8, 6'd0, 6'd0});
        end
        ren(9, 10, 9, 0, 51); #1;
        checks++;
        if (free_pop !== 1'b0) begin errors++; $display("FAIL nowr_pop: got %b expected 0", free_pop); end
        @(negedge clk);
        checks++;
        if (got_out !== {1'b1, 6'd9, 6'd10, 6'd0, 6'd0}) begin
            errors++; $display("FAIL nowr_out: got %h expected %h", got_out, {1'b1, 6'd9, 6'd10, 6'd0, 6'd0});
        end
        // History must still be empty: commit is ignored and flush starts no walk.
        clr(); commit_en = 1; flush = 1;
        @(negedge clk); clr();
        checks++;
        if ({flush_busy, free_push} !== 2'b00) begin
            errors++; $display("FAIL noalloc_hist: got %b expected 00", {flush_busy, free_push});
        end
    endtask

    task automatic test_flush_walk();
        logic [5:0] exp_p [4];
        logic [7:0] exp_w;
        exp_p[0] = 6'd0; exp_p[1] = 6'd42; exp_p[2] = 6'd41; exp_p[3] = 6'd40;
        do_reset();
        ren(0, 0, 3, 1, 40);
        @(negedge clk); ren(0, 0, 4, 1, 41);
        @(negedge clk);
        checks++;
        if (got_out !== {1'b1, 6'd0, 6'd0, 6'd41, 6'd4}) begin
            errors++; $display("FAIL walk_r2: got %h expected %h", got_out, {1'b1, 6'd0, 6'd0, 6'd41, 6'd4});
        end
        ren(0, 0, 3, 1, 42);
        @(negedge clk);
        checks++;
        if (got_out !== {1'b1, 6'd0, 6'd0, 6'd42, 6'd40}) begin
            errors++; $display("FAIL walk_r3: got %h expected %h", got_out, {1'b1, 6'd0, 6'd0, 6'd42, 6'd40});
        end
        clr(); flush = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_w = {(k < 3) ? 1'b1 : 1'b0, (k > 0) ? 1'b1 : 1'b0, exp_p[k]};
            checks++;
            if ({flush_busy, free_push, free_push_preg} !== exp_w) begin
                errors++;
                $display("FAIL walk_step%0d: got %h expected %h", k, {flush_busy, free_push, free_push_preg}, exp_w);
            end
            if (k == 0) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL walk_ready: got %b expected 0", in_ready); end
            end
        end
        clr(); ren(3, 4, 0, 0, 0);
        @(negedge clk); clr();
        checks++;
        if ({free_push, got_out} !== {1'b0, 1'b1, 6'd3, 6'd4, 6'd0, 6'd0}) begin
            errors++;
            $display("FAIL walk_map: got %h expected %h", {free_push, got_out}, {1'b0, 1'b1, 6'd3, 6'd4, 6'd0, 6'd0});
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ren(0, 0, 5'(i + 10), 1, 6'(32 + i));
            @(negedge clk);
        end
        ren(0, 0, 0, 0, 0); #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_nonalloc: got %b expected 0", in_ready); end
        ren(0, 0, 5, 1, 60); commit_en = 1; #1;
        checks++;
        if ({in_ready, free_pop} !== 2'b00) begin
            errors++; $display("FAIL full_commit_ready: got %b expected 00", {in_ready, free_pop});
        end
        @(negedge clk); commit_en = 0;
        checks++;
        if ({free_push, free_push_preg, out_valid} !== {1'b1, 6'd10, 1'b0}) begin
            errors++;
            $display("FAIL full_commit: got %h expected %h", {free_push, free_push_preg, out_valid}, {1'b1, 6'd10, 1'b0});
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b expected 1", in_ready); end
        @(negedge clk); clr();
        checks++;
        if ({free_push, got_out} !== {1'b0, 1'b1, 6'd0, 6'd0, 6'd60, 6'd5}) begin
            errors++;
            $display("FAIL full_after: got %h expected %h", {free_push, got_out}, {1'b0, 1'b1, 6'd0, 6'd0, 6'd60, 6'd5});
        end
    endtask

    task automatic test_free_empty();
        do_reset();
        ren(6, 0, 6, 1, 55); free_valid = 0; #1;
        checks++;
        if ({in_ready, free_pop} !== 2'b00) begin
            errors++; $display("FAIL empty_ready: got %b expected 00", {in_ready, free_pop});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_out: got %b expected 0", out_valid); end
        free_valid = 1; #1;
        checks++;
        if ({in_ready, free_pop} !== 2'b11) begin
            errors++; $display("FAIL refill_ready: got %b expected 11", {in_ready, free_pop});
        end
        @(negedge clk); clr(); flush = 1;
        checks++;
        if (got_out !== {1'b1, 6'd6, 6'd0, 6'd55, 6'd6}) begin
            errors++; $display("FAIL refill_out: got %h expected %h", got_out, {1'b1, 6'd6, 6'd0, 6'd55, 6'd6});
        end
        @(negedge clk); flush = 0;
        @(negedge clk);
        checks++;
        if ({flush_busy, free_push, free_push_preg} !== {1'b0, 1'b1, 6'd55}) begin
            errors++;
            $display("FAIL refill_walk: got %h expected %h", {flush_busy, free_push, free_push_preg}, {1'b0, 1'b1, 6'd55});
        end
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        ren(0, 0, 7, 1, 44);
        @(negedge clk); ren(0, 0, 8, 1, 45);
        @(negedge clk); clr(); flush = 1;
        @(negedge clk); flush = 0;
        checks++;
        if (flush_busy !== 1'b1) begin errors++; $display("FAIL midwalk_busy: got %b expected 1", flush_busy); end
        rst_n = 0; #1;
        checks++;
        if ({flush_busy, free_push, out_valid} !== 3'b000) begin
            errors++; $display("FAIL midwalk_reset: got %b expected 000", {flush_busy, free_push, out_valid});
        end
        @(negedge clk); rst_n = 1; ren(7, 8, 0, 0, 0);
        @(negedge clk); clr();
        checks++;
        if (got_out !== {1'b1, 6'd7, 6'd8, 6'd0, 6'd0}) begin
            errors++; $display("FAIL midwalk_map: got %h expected %h", got_out, {1'b1, 6'd7, 6'd8, 6'd0, 6'd0});
        end
    endtask

    initial begin
        test_reset();
        test_rename_basic();
        test_back_to_back();
        test_no_alloc();
        test_flush_walk();
        test_full();
        test_free_empty();
        test_reset_mid_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rename_map_stage.md
Name: rename_map_stage

Overview:
- Register-rename stage of the OoO MIPS core; sits between decode and the issue queue.
- Pops one free physical register per renamed destination from the free-list FIFO and keeps the arch→phys map.
- Keeps a history buffer of rename records for in-order retirement and flush recovery.
- Returns freed physical registers to the free list on commit (old mapping) and on flush walk-back (new mapping).

Parameters:
- ARCH_REGS, 32, number of architectural registers (index 0 = $zero, never renamed)
- PHYS_REGS, 64, number of physical registers
- PREG_W, 6, physical register index width, equal to $clog2(PHYS_REGS)
- HIST_DEPTH, 16, history buffer entries (max in-flight renamed destinations)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts this cycle (combinational)
- arch_rs, arch_rt, arch_rd  in  5 each  architectural operands
- rd_wr  in  1  instruction writes arch_rd
- free_valid  in  1  free list non-empty
- free_preg  in  PREG_W  free-list head value, valid while free_valid
- free_pop  out  1  free-list read enable (combinational)
- free_push  out  1  free-list write enable (registered)
- free_push_preg  out  PREG_W  register returned to free list (registered)
- out_valid  out  1  renamed instruction valid (registered)
- phys_rs, phys_rt, phys_rd, old_phys_rd  out  PREG_W each  renamed operands and previous rd mapping
- commit_en  in  1  retire oldest history record
- flush  in  1  squash all uncommitted renames
- flush_busy  out  1  high while in WALK

Behaviour:
- Reset (async):
  - map[i] = i.
  - History empty; state RUN.
  - All outputs 0: out_valid, free_push, flush_busy, and all data outputs.
- States:
  - RUN: normal rename.
  - WALK: flush recovery.
- alloc = rd_wr && arch_rd != 0.
- in_ready = RUN && !flush && !hist_full && (!alloc || free_valid).
- fire = in_valid && in_ready.
- free_pop = fire && alloc.
- Rename, one-cycle latency. On fire, the next edge registers:
  - out_valid = 1;
  - phys_rs = map[arch_rs] and phys_rt = map[arch_rt], read before this instruction's update;
  - if alloc: phys_rd = free_preg, old_phys_rd = map[arch_rd]; map[arch_rd] <= free_preg; push history record {arch_rd, new = free_preg, old = map[arch_rd]} at the tail;
  - if not alloc: phys_rd = old_phys_rd = 0, and no history push.
- out_valid = 0 in any cycle without fire.
- Back-to-back dependent instructions see the updated map, because the map is written at the edge.
- Commit:
  - In RUN, commit_en with history non-empty pops the head and registers free_push = 1, free_push_preg = head.old.
  - commit_en with history empty is ignored.
  - commit_en while in WALK is illegal; upstream holds it low (bench assertion).
- Flush:
  - flush in RUN blocks fire that cycle; an in_valid instruction is dropped.
  - If commit_en is also high, the commit is processed first, in the same edge.
  - If history is still non-empty afterwards → WALK and flush_busy = 1; otherwise stay in RUN.
- WALK, one record per cycle, youngest first:
  - map[tail.arch] <= tail.old.
  - free_push = 1 and free_push_preg = tail.new, registered.
  - Decrement tail.
  - When the last record is undone → RUN and flush_busy = 0 on the following edge.
  - flush asserted during WALK is ignored.
- Walk latency = number of uncommitted records (0..HIST_DEPTH cycles).
- History pointers are $clog2(HIST_DEPTH)-bit and wrap modulo HIST_DEPTH; occupancy counter is $clog2(HIST_DEPTH)+1 bits.
- Full history:
  - in_ready = 0 for allocating and non-allocating instructions alike.
  - A same-cycle commit does not re-open in_ready until the next cycle.
- free_push is low whenever no commit or walk step occurs.
- Reset asserted mid-WALK or mid-operation → immediate identity map, empty history, RUN.

Test Plan:
- Reset, then rename rd=5 (rs=1, rt=2), free_preg=32:
  - free_pop high that cycle;
  - next cycle out_valid=1, phys_rs=1, phys_rt=2, phys_rd=32, old_phys_rd=5.
- Back-to-back, free_preg 32 then 33:
  - A: rd=5;
  - B: rs=5, rd=5;
  - B must show phys_rs=32, phys_rd=33, old_phys_rd=32.
- Rename with rd=0 or rd_wr=0:
  - free_pop=0 and phys_rd=0;
  - history occupancy unchanged.
- Three renames (rd 3, 4, 3 → pregs 40, 41, 42), then flush:
  - flush_busy high for 3 cycles;
  - free_push_preg sequence 42, 41, 40;
  - map[3]=3 and map[4]=4 afterwards.
- Fill history with 16 renames:
  - in_ready=0;
  - commit_en → free_push_preg = old mapping of the first rename;
  - in_ready=1 on the following cycle.
- free_valid=0 with an allocating in_valid:
  - in_ready=0 and no state change.
- Then free_valid=1:
  - rename proceeds.
- Assert rst_n low mid-WALK:
  - flush_busy=0 and identity map restored.
